// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the banked masked SRAM.
package sram_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic bit params_ok(input int depth, input int data_w, input int mask_gran,
                                     input int nbanks, input int read_lat);
        if (depth < 2 || (depth & (depth - 1)) != 0) return 1'b0;
        if (mask_gran < 1 || nbanks < 1) return 1'b0;
        if ((data_w % mask_gran) != 0 || (data_w % nbanks) != 0) return 1'b0;
        if (((data_w / nbanks) % mask_gran) != 0) return 1'b0;
        if (read_lat != 1 && read_lat != 2) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/sram_rw_bank.sv
// One column bank: DEPTH x BW masked array with a registered synchronous read.
module sram_rw_bank
    import sram_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int BW        = 128,
    parameter int MASK_GRAN = 8,
    localparam int AW       = clog2(DEPTH),
    localparam int LANES    = BW / MASK_GRAN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] wmask,
    input  logic [BW-1:0]    wdata,
    output logic [BW-1:0]    rdata
);

    logic [BW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the top-level fill sequencer defines them.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) mem[addr][l*MASK_GRAN +: MASK_GRAN] <= wdata[l*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_rw_banked_init.sv
// Banked masked single-port SRAM with post-reset fill sequencer and read-valid pipeline.
module sram_rw_banked_init
    import sram_pkg::*;
#(
    parameter int                   DEPTH         = 256,
    parameter int                   DATA_W        = 256,
    parameter int                   MASK_GRAN     = 8,
    parameter int                   NBANKS        = 2,
    parameter int                   READ_LAT      = 1,
    parameter bit                   INIT_ON_RESET = 1'b1,
    parameter logic [MASK_GRAN-1:0] INIT_VALUE    = '0,
    localparam int                  AW            = clog2(DEPTH),
    localparam int                  MW            = DATA_W / MASK_GRAN
) (
    input  logic              RW0_clk,
    input  logic              RW0_reset,
    input  logic [AW-1:0]     RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MW-1:0]     RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready
);

    localparam int     BW        = DATA_W / NBANKS;
    localparam int     BM        = BW / MASK_GRAN;
    localparam state_t RST_STATE = INIT_ON_RESET ? INIT : RUN;

    if (!params_ok(DEPTH, DATA_W, MASK_GRAN, NBANKS, READ_LAT)) begin : g_bad_params
        $error("sram_rw_banked_init: illegal parameter combination");
    end

    state_t              state, state_nxt;
    logic [AW-1:0]       cnt;
    logic                filling, rd, wr, we;
    logic [AW-1:0]       b_addr;
    logic [MW-1:0]       b_mask;
    logic [DATA_W-1:0]   b_wdata, row;
    logic [READ_LAT:1]   vld_pipe;

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) state <= RST_STATE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == AW'(DEPTH - 1)) state_nxt = RUN;
    end

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset)    cnt <= '0;
        else if (filling) cnt <= cnt + 1'b1;
    end

    assign filling   = (state == INIT);
    assign RW0_ready = (state == RUN);
    assign rd        = RW0_en && RW0_ready && !RW0_wmode;
    assign wr        = RW0_en && RW0_ready && RW0_wmode;

    // The fill sequencer owns the array port while filling; user requests are dropped.
    assign we      = filling || wr;
    assign b_addr  = filling ? cnt : RW0_addr;
    assign b_mask  = filling ? '1 : RW0_wmask;
    assign b_wdata = filling ? {MW{INIT_VALUE}} : RW0_wdata;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        sram_rw_bank #(.DEPTH(DEPTH), .BW(BW), .MASK_GRAN(MASK_GRAN)) u_bank (
            .clk   (RW0_clk),
            .rst   (RW0_reset),
            .we    (we),
            .re    (rd),
            .addr  (b_addr),
            .wmask (b_mask[b*BM +: BM]),
            .wdata (b_wdata[b*BW +: BW]),
            .rdata (row[b*BW +: BW])
        );
    end

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) vld_pipe <= '0;
        else           vld_pipe <= READ_LAT'({vld_pipe, rd});
    end

    assign RW0_rvalid = vld_pipe[READ_LAT];

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata_q;
        // Only advance on a real read so rdata holds the last result.
        always_ff @(posedge RW0_clk or posedge RW0_reset) begin
            if (RW0_reset)        rdata_q <= '0;
            else if (vld_pipe[1]) rdata_q <= row;
        end
        assign RW0_rdata = rdata_q;
    end else begin : g_lat1
        assign RW0_rdata = row;
    end

endmodule

// File: tb/tb_sram_rw_banked_init.sv
// Directed bench: default array, READ_LAT=2 array and a small no-fill odd-width array.
module tb_sram_rw_banked_init;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_en = 0, a_wm = 0, a_rv, a_rdy;
    logic [7:0]   a_addr = '0;
    logic [31:0]  a_mask = '0;
    logic [255:0] a_wd = '0, a_rd;

    logic         b_en = 0, b_wm = 0, b_rv, b_rdy;
    logic [7:0]   b_addr = '0;
    logic [31:0]  b_mask = '0;
    logic [255:0] b_wd = '0, b_rd;

    logic         c_en = 0, c_wm = 0, c_rv, c_rdy;
    logic [4:0]   c_addr = '0;
    logic [3:0]   c_mask = '0;
    logic [91:0]  c_wd = '0, c_rd;

    sram_rw_banked_init u_a (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(a_addr), .RW0_en(a_en), .RW0_wmode(a_wm),
        .RW0_wmask(a_mask), .RW0_wdata(a_wd), .RW0_rdata(a_rd), .RW0_rvalid(a_rv), .RW0_ready(a_rdy)
    );

    sram_rw_banked_init #(.READ_LAT(2)) u_b (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(b_addr), .RW0_en(b_en), .RW0_wmode(b_wm),
        .RW0_wmask(b_mask), .RW0_wdata(b_wd), .RW0_rdata(b_rd), .RW0_rvalid(b_rv), .RW0_ready(b_rdy)
    );

    sram_rw_banked_init #(.DEPTH(32), .DATA_W(92), .MASK_GRAN(23), .NBANKS(1), .INIT_ON_RESET(1'b0)) u_c (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(c_addr), .RW0_en(c_en), .RW0_wmode(c_wm),
        .RW0_wmask(c_mask), .RW0_wdata(c_wd), .RW0_rdata(c_rd), .RW0_rvalid(c_rv), .RW0_ready(c_rdy)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] ad, input logic [31:0] m, input logic [255:0] d);
        a_en = 1; a_wm = 1; a_addr = ad; a_mask = m; a_wd = d;
        tick();
        a_en = 0;
    endtask

    task automatic a_read(input logic [7:0] ad, input logic [255:0] exp, input string tag);
        a_en = 1; a_wm = 0; a_addr = ad;
        tick();
        a_en = 0;
        chk({tag, "_data"}, a_rd, exp);
        chk({tag, "_rv"}, a_rv, 1);
        tick();
        chk({tag, "_rv_off"}, a_rv, 0);
    endtask

    task automatic b_write(input logic [7:0] ad, input logic [255:0] d);
        b_en = 1; b_wm = 1; b_addr = ad; b_mask = '1; b_wd = d;
        tick();
        b_en = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!a_rdy && n < 400) begin
            tick();
            n++;
        end
        chk(tag, n, 256);
    endtask

    initial begin
        logic [255:0] exp5;
        logic [255:0] pat;
        int  n;
        bit  seen;

        repeat (2) tick();
        chk("rst_a_ready", a_rdy, 0);
        chk("rst_a_rvalid", a_rv, 0);
        chk("rst_a_rdata", a_rd, 0);
        chk("rst_c_ready", c_rdy, 1);

        // Fill: a write attempted at fill cycle 10 must be dropped.
        rst = 0;
        n = 0;
        seen = 0;
        while (!a_rdy && n < 400) begin
            if (n == 10) begin
                a_en = 1; a_wm = 1; a_addr = 8'd9; a_mask = '1; a_wd = '1;
            end else begin
                a_en = 0;
            end
            tick();
            n++;
            if (a_rv) seen = 1;
        end
        a_en = 0;
        chk("fill_len", n, 256);
        chk("fill_no_rvalid", seen, 0);
        chk("b_ready", b_rdy, 1);

        // Masked writes straddling the bank boundary at bit 128.
        a_write(8'd5, 32'h0000000F, {8{32'hDEADBEEF}});
        a_write(8'd5, 32'hFFFF0000, {8{32'h0BADF00D}});
        exp5 = {{4{32'h0BADF00D}}, 96'h0, 32'hDEADBEEF};
        a_read(8'd5, exp5, "row5_mask");
        a_read(8'd0, '0, "row0");
        a_read(8'd17, '0, "row17");
        a_read(8'd255, '0, "row255");
        a_read(8'd9, '0, "row9_dropped");

        // Read then write same row: old data returned and held.
        pat = {4{64'h0123456789ABCDEF}};
        a_en = 1; a_wm = 0; a_addr = 8'd5;
        tick();
        chk("rw_old", a_rd, exp5);
        a_wm = 1; a_mask = '1; a_wd = pat;
        tick();
        a_en = 0;
        chk("rw_hold", a_rd, exp5);
        chk("rw_hold_rv", a_rv, 0);
        a_read(8'd5, pat, "wr_then_rd");
        a_write(8'd3, 32'h0, '1);
        a_read(8'd3, '0, "zero_mask_noop");
        a_write(8'd3, '1, '1);

        // READ_LAT=2 pipelined reads.
        for (int i = 1; i <= 3; i++) b_write(8'(i), 256'(i));
        b_en = 1; b_wm = 0; b_addr = 8'd1;
        tick(); chk("l2_e1_rv", b_rv, 0);
        b_addr = 8'd2;
        tick(); chk("l2_e2_rv", b_rv, 1); chk("l2_e2_rd", b_rd, 1);
        b_addr = 8'd3;
        tick(); chk("l2_e3_rv", b_rv, 1); chk("l2_e3_rd", b_rd, 2);
        b_en = 0;
        tick(); chk("l2_e4_rv", b_rv, 1); chk("l2_e4_rd", b_rd, 3);
        tick(); chk("l2_e5_rv", b_rv, 0); chk("l2_e5_rd", b_rd, 3);

        // Reset while a READ_LAT=2 read is in flight.
        b_en = 1; b_wm = 0; b_addr = 8'd2;
        tick();
        b_en = 0;
        rst = 1;
        tick();
        rst = 0;
        tick();
        chk("rst_cancel_rv", b_rv, 0);
        chk("rst_cancel_rd", b_rd, 0);

        // Second reset deep into the fill restarts it from row 0.
        repeat (98) tick();
        chk("mid_fill_ready", a_rdy, 0);
        rst = 1;
        tick();
        rst = 0;
        wait_ready("refill_len");
        a_read(8'd3, '0, "row3_refilled");
        a_read(8'd5, '0, "row5_refilled");

        // No-fill odd-width array: only lanes 0 and 2 take the second write.
        chk("c_ready_run", c_rdy, 1);
        c_en = 1; c_wm = 1; c_addr = 5'd31; c_mask = 4'b1111; c_wd = {4{23'h111111}};
        tick();
        c_mask = 4'b0101; c_wd = {4{23'h2AAAAA}};
        tick();
        c_wm = 0;
        tick();
        c_en = 0;
        chk("c_lanes", c_rd, {23'h111111, 23'h2AAAAA, 23'h111111, 23'h2AAAAA});
        chk("c_rv", c_rv, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
